euler_operand_fetch: RTL



---
 rtl/euler_operand_fetch.sv | 136 +++++++++++++
 1 files changed

// File: rtl/euler_operand_fetch.sv
// euler_operand_fetch
//   Read-side counterpart of the Euler last-pipe writer. It walks a RAM
//   region and fetches operand pairs (x_n at even offset, f_n at odd offset).
//   Each pair is presented to the add/multiply last pipe on data_pipe1/2.
//   A run of elem_count pairs starts on an accepted start and ends with a
//   one-cycle done pulse.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a run (sampled only in IDLE)
//   base_addr      : address of the first pair, latched on accepted start
//   elem_count     : number of pairs N, latched on accepted start
//   ram_rd_en      : RAM read strobe (high in FETCH_A / FETCH_B only)
//   ram_addr       : RAM read address (holds last value when idle)
//   ram_rdata      : RAM read data, valid one cycle after ram_rd_en
//   data_pipe1/2   : operand A / operand B
//   operand_valid  : data_pipe1/2 hold a valid pair
//   pipe_ready     : consumer accepts the pair this cycle
//   busy           : high from accepted start until the end of done
//   done           : one-cycle pulse after the last pair is accepted
module euler_operand_fetch #(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADD_SIZE-1:0]  base_addr,
  input  logic [ADD_SIZE-1:0]  elem_count,
  output logic                 ram_rd_en,
  output logic [ADD_SIZE-1:0]  ram_addr,
  input  logic [DATA_SIZE-1:0] ram_rdata,
  output logic [DATA_SIZE-1:0] data_pipe1,
  output logic [DATA_SIZE-1:0] data_pipe2,
  output logic                 operand_valid,
  input  logic                 pipe_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADD_SIZE-1:0] ADDR_ONE = {{(ADD_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    LATCH_B,
    PRESENT,
    FINISH
  } state_t;

  state_t              state;
  logic [ADD_SIZE-1:0] ptr;        // next address to be issued
  logic [ADD_SIZE-1:0] remaining;  // pairs not yet handed to the pipe

  // Outputs are registered, so the address/strobe belonging to a state are
  // loaded on the edge that enters it. ptr therefore always runs one word
  // ahead of ram_addr. Address arithmetic wraps modulo 2^ADD_SIZE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      remaining     <= '0;
      ram_rd_en     <= 1'b0;
      ram_addr      <= '0;
      data_pipe1    <= '0;
      data_pipe2    <= '0;
      operand_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            remaining <= elem_count;
            if (elem_count == '0) begin
              ptr   <= base_addr;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              ram_addr  <= base_addr;
              ram_rd_en <= 1'b1;
              ptr       <= base_addr + ADDR_ONE;
              state     <= FETCH_A;
            end
          end
        end

        FETCH_A: begin
          ram_addr <= ptr;
          ptr      <= ptr + ADDR_ONE;
          state    <= FETCH_B;
        end

        FETCH_B: begin
          // ram_rdata now carries the word addressed in FETCH_A
          data_pipe1 <= ram_rdata;
          ram_rd_en  <= 1'b0;
          state      <= LATCH_B;
        end

        LATCH_B: begin
          data_pipe2    <= ram_rdata;
          operand_valid <= 1'b1;
          state         <= PRESENT;
        end

        PRESENT: begin
          if (pipe_ready) begin
            operand_valid <= 1'b0;
            remaining     <= remaining - ADDR_ONE;
            if (remaining == ADDR_ONE) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              ram_addr  <= ptr;
              ram_rd_en <= 1'b1;
              ptr       <= ptr + ADDR_ONE;
              state     <= FETCH_A;
            end
          end
        end

        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
